// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM slave controller.
package i2c_eeprom_pkg;

    // Protocol engine states; ACK slots are a sub-phase of each byte state.
    typedef enum logic [2:0] {
        StIdle,
        StDevAddr,
        StWordAddr,
        StWrData,
        StRdData,
        StRdAck
    } state_e;

    // Bit counter value marking the ninth (ACK) slot of a byte.
    localparam logic [3:0] BIT_CNT_ACK = 4'd8;

    // Bus levels of the acknowledge bit.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0]  DEFAULT_DEV_ADDR = 7'h50;
    localparam int unsigned DEFAULT_BYTE_NUM = 8;
    localparam int unsigned DEFAULT_ADDR_W   = 3;

endpackage

// File: rtl/i2c_eeprom_slave_ctrl_if.sv
// Page memory port between the protocol engine and the 8-byte page.
interface i2c_eeprom_slave_ctrl_if #(
    parameter int unsigned ADDR_W = i2c_eeprom_pkg::DEFAULT_ADDR_W
);
    logic              mem_cs;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    // Controller side.
    modport master (
        output mem_cs,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    // Page memory side.
    modport slave (
        input  mem_cs,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk and produces registered one-clk event pulses.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;
    logic scl_rise_q, scl_fall_q, start_q, stop_q;

    // Two-flop synchronizers, previous-value flops and pulse registers; idle bus is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
            scl_rise_q <= scl_sync_q & ~scl_prev_q;
            scl_fall_q <= ~scl_sync_q & scl_prev_q;
            // SDA transitions only count as conditions while SCL is stably high.
            start_q    <= scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
            stop_q     <= scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
        end
    end

    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    // Aligned with the pulses: the SDA level seen when SCL rose.
    assign sda_s     = sda_prev_q;

endmodule

// File: rtl/i2c_eeprom_slave_ctrl.sv
// I2C slave protocol engine driving a one-page EEPROM memory port.
module i2c_eeprom_slave_ctrl
    import i2c_eeprom_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = DEFAULT_DEV_ADDR,
    parameter int unsigned BYTE_NUM = DEFAULT_BYTE_NUM,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_oe,
    i2c_eeprom_slave_ctrl_if.master mem_if
);
    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_e            state_q;
    logic [3:0]        bit_cnt_q;
    // Seven bits suffice: the eighth received bit comes straight from sda_s, and on
    // transmit the MSB is already on the bus when the byte is loaded.
    logic [6:0]        shift_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ack_phase_q;
    logic              rd_req_q;
    logic              rd_load_q;
    logic              sda_oe_q;
    logic              mem_cs_q;
    logic              mem_write_q;
    logic [7:0]        mem_wdata_q;
    logic [7:0]        rx_byte;

    assign rx_byte = {shift_q, sda_s};

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        return ADDR_W'((32'(p) + 32'd1) % BYTE_NUM);
    endfunction

    // Protocol FSM with registered SDA drive and memory strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            ack_phase_q <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_load_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_cs_q    <= 1'b0;
            mem_write_q <= 1'b0;
            // Advance only after the write pulse so the write lands at the old pointer.
            if (mem_write_q) begin
                ptr_q <= ptr_next(ptr_q);
            end

            if (stop_det) begin
                state_q     <= StIdle;
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
                rd_load_q   <= 1'b0;
                sda_oe_q    <= 1'b0;
            end else if (start_det) begin
                state_q     <= StDevAddr;
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
                rd_load_q   <= 1'b0;
                sda_oe_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end

                    StDevAddr, StWordAddr, StWrData: begin
                        if (scl_rise && bit_cnt_q != BIT_CNT_ACK) begin
                            shift_q   <= rx_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == BIT_CNT_ACK - 4'd1) begin
                                case (state_q)
                                    StDevAddr: begin
                                        if (rx_byte[7:1] == DEV_ADDR) begin
                                            rd_req_q <= rx_byte[0];
                                        end else begin
                                            state_q <= StIdle;
                                        end
                                    end
                                    StWordAddr: ptr_q <= rx_byte[ADDR_W-1:0];
                                    StWrData: begin
                                        mem_wdata_q <= rx_byte;
                                        mem_cs_q    <= 1'b1;
                                        mem_write_q <= 1'b1;
                                    end
                                    default: begin
                                    end
                                endcase
                            end
                        end else if (scl_fall && bit_cnt_q == BIT_CNT_ACK) begin
                            if (!ack_phase_q) begin
                                // First fall after the byte: pull SDA low for the ACK slot.
                                ack_phase_q <= 1'b1;
                                sda_oe_q    <= ~ACK;
                            end else begin
                                ack_phase_q <= 1'b0;
                                bit_cnt_q   <= '0;
                                sda_oe_q    <= 1'b0;
                                case (state_q)
                                    StDevAddr: begin
                                        if (rd_req_q) begin
                                            state_q  <= StRdData;
                                            shift_q  <= mem_if.mem_rdata[6:0];
                                            sda_oe_q <= ~mem_if.mem_rdata[7];
                                        end else begin
                                            state_q <= StWordAddr;
                                        end
                                    end
                                    StWordAddr: state_q <= StWrData;
                                    default: begin
                                    end
                                endcase
                            end
                        end
                    end

                    StRdData: begin
                        if (scl_rise && bit_cnt_q != BIT_CNT_ACK) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (rd_load_q) begin
                                rd_load_q <= 1'b0;
                                shift_q   <= mem_if.mem_rdata[6:0];
                                sda_oe_q  <= ~mem_if.mem_rdata[7];
                            end else if (bit_cnt_q == BIT_CNT_ACK) begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= StRdAck;
                            end else begin
                                sda_oe_q <= ~shift_q[6];
                                shift_q  <= {shift_q[5:0], 1'b0};
                            end
                        end
                    end

                    StRdAck: begin
                        if (scl_rise) begin
                            if (sda_s == ACK) begin
                                ptr_q     <= ptr_next(ptr_q);
                                bit_cnt_q <= '0;
                                rd_load_q <= 1'b1;
                                state_q   <= StRdData;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end

                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign sda_oe           = sda_oe_q;
    assign mem_if.mem_cs    = mem_cs_q;
    assign mem_if.mem_write = mem_write_q;
    assign mem_if.mem_addr  = ptr_q;
    assign mem_if.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_i2c_eeprom_slave_ctrl.sv
// Bench: bit-banged I2C master, page memory model and scoreboard monitors.
module tb_i2c_eeprom_slave_ctrl;
    import i2c_eeprom_pkg::*;

    localparam int          Q   = 50;     // quarter SCL period, 5 clk
    localparam logic [6:0]  DEV = 7'h50;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic sda_oe;
    logic sda_bus;
    logic slot_slave = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_eeprom_slave_ctrl_if #(.ADDR_W(3)) mif ();

    i2c_eeprom_slave_ctrl #(
        .DEV_ADDR (DEV),
        .BYTE_NUM (8),
        .ADDR_W   (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .scl_i  (scl),
        .sda_i  (sda_bus),
        .sda_oe (sda_oe),
        .mem_if (mif)
    );

    always #5 clk = ~clk;

    // Page memory seen by the DUT.
    logic [7:0] page [8] = '{default: 8'h00};
    assign mif.mem_rdata = page[mif.mem_addr];
    always @(posedge clk) begin
        if (mif.mem_cs && mif.mem_write) page[mif.mem_addr] <= mif.mem_wdata;
    end

    // Reference model state and scoreboard queues.
    logic [7:0] ref_mem [8] = '{default: 8'h00};
    int         ref_ptr = 0;
    wr_t        exp_wr[$];
    logic       exp_bit[$];
    logic [7:0] buf_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Write monitor: every memory strobe must match the next expected write.
    always @(negedge clk) begin
        wr_t e;
        if (mif.mem_cs || mif.mem_write) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got addr %0h data %0h want none",
                         mif.mem_addr, mif.mem_wdata);
            end else begin
                e = exp_wr.pop_front();
                check("wr_strobe", {mif.mem_cs, mif.mem_write}, 2'b11);
                check("wr_addr", mif.mem_addr, e.addr);
                check("wr_data", mif.mem_wdata, e.data);
            end
        end
    end

    // Bus monitor: slave-owned bit slots are compared when SCL rises.
    always @(posedge scl) begin
        if (slot_slave) begin
            if (exp_bit.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bit_underflow got %0b want queued bit", sda_bus);
            end else begin
                check("sda_bit", sda_bus, exp_bit.pop_front());
            end
        end
    end

    // One SCL clock; entered and left with SCL low.
    task automatic clk_bit(input logic b, input logic slave_owned, input logic exp);
        #Q;
        sda_m = slave_owned ? 1'b1 : b;
        slot_slave = slave_owned;
        if (slave_owned) exp_bit.push_back(exp);
        #Q;
        scl = 1'b1;
        #(2 * Q);
        scl = 1'b0;
    endtask

    task automatic start_c();
        slot_slave = 1'b0;
        if (scl == 1'b0) begin
            #Q;
            sda_m = 1'b1;
            #Q;
            scl = 1'b1;
        end
        #Q;
        sda_m = 1'b0;
        #Q;
        scl = 1'b0;
    endtask

    task automatic stop_c();
        slot_slave = 1'b0;
        #Q;
        sda_m = 1'b0;
        #Q;
        scl = 1'b1;
        #Q;
        sda_m = 1'b1;
        #(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0, 1'b0);
        clk_bit(1'b1, 1'b1, exp_ack);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic mack);
        for (int i = 7; i >= 0; i--) clk_bit(1'b0, 1'b1, exp[i]);
        clk_bit(mack, 1'b0, 1'b0);
    endtask

    // Write transaction of the bytes in buf_q starting at word address.
    task automatic write_txn(input logic [7:0] word);
        start_c();
        send_byte({DEV, 1'b0}, ACK);
        send_byte(word, ACK);
        ref_ptr = word % 8;
        foreach (buf_q[i]) begin
            exp_wr.push_back(wr_t'{addr: 3'(ref_ptr), data: buf_q[i]});
            ref_mem[ref_ptr] = buf_q[i];
            ref_ptr = (ref_ptr + 1) % 8;
            send_byte(buf_q[i], ACK);
        end
        stop_c();
    endtask

    // Read n bytes, optionally after setting the address with a dummy write.
    task automatic read_txn(input logic set_addr, input logic [7:0] word, input int n);
        logic mack;
        start_c();
        if (set_addr) begin
            send_byte({DEV, 1'b0}, ACK);
            send_byte(word, ACK);
            ref_ptr = word % 8;
            start_c();
        end
        send_byte({DEV, 1'b1}, ACK);
        for (int k = 0; k < n; k++) begin
            mack = (k == n - 1) ? NACK : ACK;
            read_byte(ref_mem[ref_ptr], mack);
            if (mack == ACK) ref_ptr = (ref_ptr + 1) % 8;
        end
        stop_c();
    endtask

    task automatic mismatch_txn();
        logic [6:0] d;
        d = 7'($urandom);
        while (d == DEV) d = 7'($urandom);
        start_c();
        send_byte({d, 1'($urandom)}, NACK);
        send_byte(8'($urandom), NACK);
        stop_c();
    endtask

    initial begin
        logic [7:0] a0;
        int         op;
        int         n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_mem_cs", mif.mem_cs, 1'b0);
        check("rst_mem_write", mif.mem_write, 1'b0);
        check("rst_mem_wdata", mif.mem_wdata, 8'h00);
        check("rst_mem_addr", mif.mem_addr, 3'd0);

        // Two-byte write at address 2.
        buf_q = '{8'h11, 8'h22};
        write_txn(8'h02);
        // Page wrap: 6, 7, 0; pointer ends at 1.
        buf_q = '{8'hAA, 8'hBB, 8'hCC};
        write_txn(8'h06);
        repeat (5) @(negedge clk);
        check("wrap_ptr", mif.mem_addr, 3'(ref_ptr));
        // Random read from 3: master ACK then NACK.
        read_txn(1'b1, 8'h03, 2);
        repeat (5) @(negedge clk);
        check("rd_release", sda_oe, 1'b0);
        // Address mismatch is ignored.
        mismatch_txn();

        // STOP after four data bits: no write, pointer keeps the word address.
        start_c();
        send_byte({DEV, 1'b0}, ACK);
        send_byte(8'hF5, ACK);
        ref_ptr = 5;
        for (int i = 0; i < 4; i++) clk_bit(1'($urandom), 1'b0, 1'b0);
        stop_c();
        repeat (5) @(negedge clk);
        check("stop_sda_oe", sda_oe, 1'b0);
        read_txn(1'b0, 8'h00, 1);

        // Reset while the device-address ACK is being driven.
        buf_q = '{8'h5A};
        write_txn(8'h00);
        start_c();
        a0 = {DEV, 1'b0};
        for (int i = 7; i >= 0; i--) clk_bit(a0[i], 1'b0, 1'b0);
        for (int k = 0; k < 20 && !sda_oe; k++) @(negedge clk);
        check("ack_drive", sda_oe, 1'b1);
        check("ptr_before_rst", mif.mem_addr, 3'(ref_ptr));
        rst = 1'b1;
        @(negedge clk);
        check("rst_ack_sda_oe", sda_oe, 1'b0);
        check("rst_ack_ptr", mif.mem_addr, 3'd0);
        rst = 1'b0;
        ref_ptr = 0;
        stop_c();
        read_txn(1'b0, 8'h00, 1);

        // Randomized traffic.
        for (int t = 0; t < 20; t++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    n = $urandom_range(1, 9);
                    buf_q = {};
                    for (int i = 0; i < n; i++) buf_q.push_back(8'($urandom));
                    write_txn(8'($urandom));
                end
                1: read_txn(1'b0, 8'h00, $urandom_range(1, 4));
                2: read_txn(1'b1, 8'($urandom), $urandom_range(1, 4));
                default: mismatch_txn();
            endcase
        end

        repeat (10) @(negedge clk);
        check("exp_wr_empty", exp_wr.size(), 0);
        check("exp_bit_empty", exp_bit.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL timeout got running want finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
